// File: rtl/game_pkg.sv
// Shared phase encodings, widths and mode constants for the whack-a-mole game-control slice.
package game_pkg;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_COUNT = 2'd1;
   localparam logic [1:0] PH_PLAY  = 2'd2;
   localparam logic [1:0] PH_DONE  = 2'd3;

   localparam int unsigned SCORE_W = 14;

   localparam logic [1:0] MODE_OFF = 2'b00;

   typedef enum logic [1:0] {
      StIdle  = PH_IDLE,
      StCount = PH_COUNT,
      StPlay  = PH_PLAY,
      StDone  = PH_DONE
   } phase_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history flop plus an AND; a held-high level yields a single pulse.
module rise_detect (
   input  logic clock_i,
   input  logic reset_i,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Game-phase sequencer (idle/countdown/play/done) and saturating score keeper.
// Define GAME_SCORE_HIGH_SCORE_EN to build the best-score register behind high_score_o.
module game_score_ctrl
   import game_pkg::*;
#(
   parameter int unsigned COUNTDOWN_SECS = 3,
   parameter int unsigned GAME_SECS      = 30,
   parameter int unsigned SCORE_MAX      = 9999,
   parameter int unsigned MISS_PENALTY   = 1
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               tick_1hz_i,
   input  logic [1:0]         mode_i,
   input  logic               start_i,
   input  logic               whacked_i,
   input  logic               miss_i,
   output logic [1:0]         phase_o,
   output logic [3:0]         count_o,
   output logic [6:0]         time_left_o,
   output logic [SCORE_W-1:0] score_o,
   output logic               game_active_o,
   output logic [SCORE_W-1:0] high_score_o
);

   localparam logic [3:0]         CountInit = 4'(COUNTDOWN_SECS);
   localparam logic [6:0]         TimeInit  = 7'(GAME_SECS);
   localparam logic [SCORE_W-1:0] ScoreMax  = SCORE_W'(SCORE_MAX);
   localparam logic signed [15:0] ScoreMaxS = 16'(SCORE_MAX);
   localparam logic signed [15:0] PenaltyS  = 16'(MISS_PENALTY);

   logic start_rise, whack_rise, miss_rise;

   rise_detect u_start_rise (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .d_i     (start_i),
      .rise_o  (start_rise)
   );

   rise_detect u_whack_rise (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .d_i     (whacked_i),
      .rise_o  (whack_rise)
   );

   rise_detect u_miss_rise (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .d_i     (miss_i),
      .rise_o  (miss_rise)
   );

   phase_e             state_q, state_d;
   logic [3:0]         count_q, count_d;
   logic [6:0]         time_q, time_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               active_q;
   logic               game_over;

   logic signed [15:0] score_sum;
   logic [SCORE_W-1:0] score_next;

   // Signed intermediate so a miss at zero clamps instead of wrapping.
   always_comb begin
      score_sum = $signed({2'b00, score_q})
                + (whack_rise ? 16'sd1 : 16'sd0)
                - (miss_rise ? PenaltyS : 16'sd0);
      if (score_sum < 16'sd0) begin
         score_next = '0;
      end else if (score_sum > ScoreMaxS) begin
         score_next = ScoreMax;
      end else begin
         score_next = score_sum[SCORE_W-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      time_d    = time_q;
      score_d   = score_q;
      game_over = 1'b0;
      if (mode_i == MODE_OFF) begin
         state_d = StIdle;
         count_d = '0;
         time_d  = '0;
         score_d = '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start_rise) begin
                  state_d = StCount;
                  count_d = CountInit;
                  time_d  = TimeInit;
                  score_d = '0;
               end
            end
            StCount: begin
               if (tick_1hz_i) begin
                  if (count_q == 4'd1) begin
                     state_d = StPlay;
                     count_d = '0;
                  end else begin
                     count_d = count_q - 4'd1;
                  end
               end
            end
            StPlay: begin
               score_d = score_next;
               if (tick_1hz_i) begin
                  if (time_q == 7'd1) begin
                     state_d   = StDone;
                     time_d    = '0;
                     game_over = 1'b1;
                  end else begin
                     time_d = time_q - 7'd1;
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= StIdle;
         count_q  <= '0;
         time_q   <= '0;
         score_q  <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         time_q   <= time_d;
         score_q  <= score_d;
         active_q <= (state_d == StPlay);
      end
   end

`ifdef GAME_SCORE_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q;

   // score_d already includes any edge counted in the final-tick cycle.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         high_q <= '0;
      end else if (game_over && (score_d > high_q)) begin
         high_q <= score_d;
      end
   end

   assign high_score_o = high_q;
`else
   assign high_score_o = '0;
`endif

   assign phase_o       = state_q;
   assign count_o       = count_q;
   assign time_left_o   = time_q;
   assign score_o       = score_q;
   assign game_active_o = active_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Self-checking bench for game_score_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-level reference model.
module tb_game_score_ctrl;

   localparam int CD  = 3;
   localparam int GS  = 30;
   localparam int MAX = 5;
   localparam int PEN = 1;

`ifdef GAME_SCORE_HIGH_SCORE_EN
   localparam bit HsEn = 1'b1;
`else
   localparam bit HsEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        tick = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        start = 1'b0;
   logic        whack = 1'b0;
   logic        miss = 1'b0;
   logic [1:0]  phase;
   logic [3:0]  count;
   logic [6:0]  time_left;
   logic [13:0] score;
   logic        active;
   logic [13:0] high;

   int n_pass  = 0;
   int n_total = 0;

   game_score_ctrl #(
      .COUNTDOWN_SECS (CD),
      .GAME_SECS      (GS),
      .SCORE_MAX      (MAX),
      .MISS_PENALTY   (PEN)
   ) dut (
      .clock_i       (clk),
      .reset_i       (rst_n),
      .tick_1hz_i    (tick),
      .mode_i        (mode),
      .start_i       (start),
      .whacked_i     (whack),
      .miss_i        (miss),
      .phase_o       (phase),
      .count_o       (count),
      .time_left_o   (time_left),
      .score_o       (score),
      .game_active_o (active),
      .high_score_o  (high)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: phases as 0..3, plain integer arithmetic on game rules.
   int m_phase = 0, m_count = 0, m_time = 0, m_score = 0, m_high = 0;
   bit p_start = 0, p_whack = 0, p_miss = 0;
   bit sr, wr, mr;
   int v;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_count = 0; m_time = 0; m_score = 0; m_high = 0;
         p_start = 0; p_whack = 0; p_miss = 0;
      end else begin
         sr = start && !p_start;
         wr = whack && !p_whack;
         mr = miss && !p_miss;
         p_start = start; p_whack = whack; p_miss = miss;
         if (mode == 2'b00) begin
            m_phase = 0; m_count = 0; m_time = 0; m_score = 0;
         end else if (m_phase == 0 || m_phase == 3) begin
            if (sr) begin
               m_phase = 1; m_count = CD; m_time = GS; m_score = 0;
            end
         end else if (m_phase == 1) begin
            if (tick) begin
               m_count = m_count - 1;
               if (m_count == 0) m_phase = 2;
            end
         end else begin
            v = m_score + (wr ? 1 : 0) - (mr ? PEN : 0);
            if (v < 0) v = 0;
            if (v > MAX) v = MAX;
            m_score = v;
            if (tick) begin
               m_time = m_time - 1;
               if (m_time == 0) begin
                  m_phase = 3;
                  if (HsEn && m_score > m_high) m_high = m_score;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("phase", phase, m_phase);
      check("count", count, m_count);
      check("time_left", time_left, m_time);
      check("score", score, m_score);
      check("game_active", active, (m_phase == 2) ? 1 : 0);
      check("high_score", high, m_high);
   end

   task automatic pulse(input bit s, input bit w, input bit m, input bit t);
      @(posedge clk); #2;
      start = s; whack = w; miss = m; tick = t;
      @(posedge clk); #2;
      start = 0; whack = 0; miss = 0; tick = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse(0, 0, 0, 1);
   endtask

   task automatic expect_out(input string tag, input int ph, input int cnt, input int tl,
                             input int sc, input int hs);
      check({tag, ".phase"}, phase, ph);
      check({tag, ".count"}, count, cnt);
      check({tag, ".time_left"}, time_left, tl);
      check({tag, ".score"}, score, sc);
      check({tag, ".active"}, active, (ph == 2) ? 1 : 0);
      check({tag, ".high"}, high, hs);
   endtask

   initial begin
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk); expect_out("reset", 0, 0, 0, 0, 0);

      mode = 2'b01;
      pulse(1, 0, 0, 0);
      @(negedge clk); expect_out("enter_count", 1, 3, 30, 0, 0);
      ticks(2);
      @(negedge clk); expect_out("count_1", 1, 1, 30, 0, 0);
      ticks(1);
      @(negedge clk); expect_out("enter_play", 2, 0, 30, 0, 0);

      for (int i = 0; i < 5; i++) pulse(0, 1, 0, 0);
      @(negedge clk); check("five_whacks", score, 5);
      for (int i = 0; i < 2; i++) pulse(0, 0, 1, 0);
      @(negedge clk); check("two_misses", score, 3);
      @(posedge clk); #2 whack = 1;
      repeat (100) @(posedge clk);
      #2 whack = 0;
      @(negedge clk); check("held_whack", score, 4);
      pulse(0, 0, 1, 0);
      pulse(0, 1, 1, 0);
      @(negedge clk); check("whack_and_miss", score, 3);
      for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0);
      pulse(0, 0, 1, 0);
      @(negedge clk); check("miss_at_zero", score, 0);
      pulse(1, 0, 0, 0);
      @(negedge clk); expect_out("start_in_play", 2, 0, 30, 0, 0);
      for (int i = 0; i < 7; i++) pulse(0, 1, 0, 0);
      @(negedge clk); check("saturate", score, 5);
      ticks(29);
      @(negedge clk); expect_out("last_second", 2, 0, 1, 5, 0);
      ticks(1);
      @(negedge clk); expect_out("game1_done", 3, 0, 0, 5, HsEn ? 5 : 0);
      pulse(0, 1, 0, 0);
      @(negedge clk); check("whack_in_done", score, 5);

      pulse(1, 0, 0, 0);
      @(negedge clk); expect_out("game2_count", 1, 3, 30, 0, HsEn ? 5 : 0);
      ticks(3);
      pulse(0, 1, 0, 0);
      ticks(29);
      pulse(0, 1, 0, 1);
      @(negedge clk); expect_out("game2_done", 3, 0, 0, 2, HsEn ? 5 : 0);

      pulse(1, 0, 0, 0);
      ticks(3);
      pulse(0, 1, 0, 0);
      @(posedge clk); #2 mode = 2'b00;
      @(posedge clk); #2;
      @(negedge clk); expect_out("mode_off", 0, 0, 0, 0, HsEn ? 5 : 0);
      pulse(0, 1, 0, 0);
      @(negedge clk); check("whack_in_idle", score, 0);

      mode = 2'b10;
      pulse(1, 0, 0, 0);
      ticks(1);
      @(posedge clk); #2 rst_n = 0;
      #1 expect_out("async_reset", 0, 0, 0, 0, 0);
      @(posedge clk); #2 rst_n = 1;

      for (int i = 0; i < 20000; i++) begin
         @(posedge clk); #2;
         mode  = ($urandom_range(0, 399) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         start = ($urandom_range(0, 49) == 0);
         tick  = ($urandom_range(0, 3) == 0);
         whack = ($urandom_range(0, 2) == 0);
         miss  = ($urandom_range(0, 4) == 0);
         rst_n = ($urandom_range(0, 3999) != 0);
      end
      @(posedge clk); #2 rst_n = 1;
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/game_score_ctrl.md
# game_score_ctrl

Game-phase controller and score keeper for the whack-a-mole design; sits directly downstream of the whack handler and mole handler. It sequences idle, countdown, play and post-game phases from a 1 Hz tick, and counts whacks and misses into a saturating score. Its phase, countdown and score outputs feed the binary-to-BCD converter and the seven-segment display driver.

## Interface
- COUNTDOWN_SECS, 3: countdown length in seconds (1–9)
- GAME_SECS, 30: play length in seconds (1–99)
- SCORE_MAX, 9999: score saturation ceiling
- MISS_PENALTY, 1: points subtracted per miss
- clock_i  in  1  system clock, 100 MHz
- reset_i  in  1  asynchronous, active-low reset
- tick_1hz_i  in  1  single-cycle enable pulse, once per second, synchronous to clock_i
- mode_i  in  2  difficulty select from mode selection; 2'b00 = off
- start_i  in  1  start request, level; a rising edge acts as the request
- whacked_i  in  1  hit indication from whack handler, level; each rising edge is one hit
- miss_i  in  1  mole-expired indication from mole handler, level; each rising edge is one miss
- phase_o  out  2  current phase (IDLE/COUNT/PLAY/DONE)
- count_o  out  4  countdown seconds remaining
- time_left_o  out  7  play seconds remaining
- score_o  out  14  current score, 0..SCORE_MAX
- game_active_o  out  1  high only in PLAY
- high_score_o  out  14  best score since reset (see Configuration)

## Operation
- States and transitions:
  - IDLE → COUNT on a start edge with mode_i != 0.
  - COUNT → PLAY on a tick with count_o == 1.
  - PLAY → DONE on a tick with time_left_o == 1.
  - DONE → COUNT on a start edge with mode_i != 0.
- mode_i == 0 forces IDLE from any state on the next clock. count_o, time_left_o and score_o are cleared; high_score_o is kept.
- Entering COUNT:
  - count_o ← COUNTDOWN_SECS
  - score_o ← 0
  - time_left_o ← GAME_SECS
- COUNT: count_o decrements by 1 on each tick.
- Entering PLAY: count_o ← 0.
- PLAY: time_left_o decrements by 1 on each tick.
- DONE: score_o and time_left_o (0) are held.
- Start edges are ignored in COUNT and PLAY.
- Whack and miss edges are counted only when the state is PLAY in the edge cycle. This includes the cycle of the final tick. Edges in any other state are discarded.
- Score arithmetic, applied once per cycle:
  - net = +1 (whack edge) − MISS_PENALTY (miss edge)
  - Both edges in the same cycle apply both terms.
  - Result is clamped to the range [0, SCORE_MAX] using a 16-bit signed intermediate.
  - Score never wraps.
- All edge detectors capture the previous input value in a register. A level held high counts once.
- Reset values:
  - phase_o = IDLE
  - count_o = 0, time_left_o = 0
  - score_o = 0, high_score_o = 0
  - game_active_o = 0
  - all edge-history registers = 0
- Reset asserted mid-game returns immediately (asynchronously) to these values.

## Timing
- All outputs are registered.
- Input high first sampled at clock edge n (previous sample low) → score_o updated at edge n+1.
- Tick sampled at edge n → count_o, time_left_o and phase_o change at edge n+1.
- Start edge sampled at n → phase_o = COUNT at n+1.
- A tick in the same cycle as the entry into COUNT or PLAY has no effect on the new state's counter.
- game_active_o is asserted on exactly the same cycles as phase_o == PLAY.

## Configuration
- GAME_SCORE_HIGH_SCORE_EN defined:
  - On the PLAY→DONE transition, if the final score > high_score_o, then high_score_o ← final score.
  - The final score includes any edge counted in the transition cycle.
  - high_score_o is cleared only by reset.
- GAME_SCORE_HIGH_SCORE_EN not defined: high_score_o is tied to 0 and no register is built.

## Structure
- Shared package game_pkg holds:
  - phase constants PH_IDLE=2'd0, PH_COUNT=2'd1, PH_PLAY=2'd2, PH_DONE=2'd3
  - SCORE_W=14
  - MODE_OFF=2'b00
- Sub-module rise_detect: one flop plus AND, same clock and reset. It is instantiated three times, for start_i, whacked_i and miss_i.
- The FSM, counters and score datapath live in game_score_ctrl.

## Test plan
- Reset, then mode_i=01 and a start pulse → phase_o goes IDLE→COUNT next cycle with count_o=3. After 3 ticks: phase_o=PLAY, time_left_o=30, game_active_o=1.
- In PLAY: 5 whack pulses, then 2 miss pulses → score_o=3. Then whacked_i held high for 100 cycles → score_o=4.
- Score 0 in PLAY, miss edge → score_o stays 0. Whack and miss edges in the same cycle with score 3 → score_o=3.
- SCORE_MAX=5 with 7 whack edges → score_o=5. 30 ticks → phase_o=DONE, score held at 5, and with the macro defined high_score_o=5. A second game scoring 2 leaves high_score_o=5.
- mode_i→00 mid-PLAY → IDLE next cycle, score_o=0. reset_i low mid-COUNT → all outputs at reset values immediately, without waiting for a clock.
- Start edge during PLAY → ignored. Whack edge in IDLE or DONE → score unchanged.
